// File: rtl/ps2_key_decoder_if.sv
// PS/2 pin pair plus the decoded byte/command outputs of ps2_key_decoder.
// The keyboard side is the master, the decoder is the slave.
interface ps2_key_decoder_if;
    logic       ps2_clk;
    logic       ps2_data;
    logic [2:0] keyboard_signal;
    logic       key_valid;
    logic [7:0] scan_byte;
    logic       byte_valid;
    logic       frame_err;

    modport master (
        output ps2_clk,
        output ps2_data,
        input  keyboard_signal,
        input  key_valid,
        input  scan_byte,
        input  byte_valid,
        input  frame_err
    );

    modport slave (
        input  ps2_clk,
        input  ps2_data,
        output keyboard_signal,
        output key_valid,
        output scan_byte,
        output byte_valid,
        output frame_err
    );
endinterface

// File: rtl/ps2_key_decoder.sv
// PS/2 scan-code-set-2 receiver and Tetris command decoder.
// Optional TYPEMATIC_FILTER_EN: held-key mask that suppresses auto-repeat pulses.
module ps2_key_decoder #(
    parameter int TIMEOUT_CYCLES = 20000
) (
    input  logic             clk,
    input  logic             rst_n,
    ps2_key_decoder_if.slave bus
);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TO_MAX = TW'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {
        S_IDLE,
        S_EXT,
        S_BRK,
        S_EXT_BRK
    } state_t;

    logic [1:0]    clkSync;
    logic [1:0]    dataSync;
    logic          clkPrev;
    logic          fallEdge;
    logic          dataBit;
    logic [3:0]    bitCnt;
    logic [7:0]    shiftReg;
    logic          parityBit;
    logic [TW-1:0] idleCnt;
    logic          timeoutHit;
    logic [7:0]    scanByte;
    logic          byteValid;
    logic          frameErr;
    logic [2:0]    keyCode;
    logic          keyValid;
    state_t        state;
    state_t        stateNext;
    logic [2:0]    cmdNext;
    logic          letterHit;
    logic [1:0]    letterIdx;
    logic          arrowHit;
    logic [1:0]    arrowIdx;
`ifdef TYPEMATIC_FILTER_EN
    logic [3:0]    heldMask;
    logic [3:0]    heldNext;
`endif

    assign fallEdge   = clkPrev & ~clkSync[1];
    assign dataBit    = dataSync[1];
    assign timeoutHit = (bitCnt != 4'd0) && (idleCnt == TO_MAX);

    // Two-flop synchronisers; clkPrev delays the clock once more for edge detect
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            clkSync  <= 2'b11;
            dataSync <= 2'b11;
            clkPrev  <= 1'b1;
        end else begin
            clkSync  <= {clkSync[0], bus.ps2_clk};
            dataSync <= {dataSync[0], bus.ps2_data};
            clkPrev  <= clkSync[1];
        end
    end

    // Cycles since the last ps2_clk falling edge, saturating
    always_ff @(posedge clk) begin
        if (!rst_n || fallEdge) begin
            idleCnt <= '0;
        end else if (idleCnt != TO_MAX) begin
            idleCnt <= idleCnt + 1'b1;
        end
    end

    // Frame receiver: start, 8 data LSB first, odd parity, stop
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bitCnt    <= 4'd0;
            shiftReg  <= 8'h00;
            parityBit <= 1'b0;
            scanByte  <= 8'h00;
            byteValid <= 1'b0;
            frameErr  <= 1'b0;
        end else begin
            byteValid <= 1'b0;
            frameErr  <= 1'b0;
            if (fallEdge) begin
                if (bitCnt == 4'd0) begin
                    if (!dataBit) bitCnt <= 4'd1;
                end else if (bitCnt <= 4'd8) begin
                    shiftReg <= {dataBit, shiftReg[7:1]};
                    bitCnt   <= bitCnt + 4'd1;
                end else if (bitCnt == 4'd9) begin
                    parityBit <= dataBit;
                    bitCnt    <= 4'd10;
                end else begin
                    bitCnt <= 4'd0;
                    if (dataBit && (^{shiftReg, parityBit})) begin
                        scanByte  <= shiftReg;
                        byteValid <= 1'b1;
                    end else begin
                        frameErr <= 1'b1;
                    end
                end
            end else if (timeoutHit) begin
                bitCnt   <= 4'd0;
                frameErr <= 1'b1;
            end
        end
    end

    // Letter keys S/A/D/W -> command index down/left/right/rotate
    always_comb begin
        letterHit = 1'b1;
        letterIdx = 2'd0;
        case (scanByte)
            8'h1B:   letterIdx = 2'd0;
            8'h1C:   letterIdx = 2'd1;
            8'h23:   letterIdx = 2'd2;
            8'h1D:   letterIdx = 2'd3;
            default: letterHit = 1'b0;
        endcase
    end

    // Extended arrow keys -> same command indices as the letters
    always_comb begin
        arrowHit = 1'b1;
        arrowIdx = 2'd0;
        case (scanByte)
            8'h72:   arrowIdx = 2'd0;
            8'h6B:   arrowIdx = 2'd1;
            8'h74:   arrowIdx = 2'd2;
            8'h75:   arrowIdx = 2'd3;
            default: arrowHit = 1'b0;
        endcase
    end

    // Decoder next state and command, evaluated only on a fresh byte
    always_comb begin
        stateNext = state;
        cmdNext   = 3'b000;
`ifdef TYPEMATIC_FILTER_EN
        heldNext  = heldMask;
`endif
        if (byteValid) begin
            unique case (state)
                S_IDLE: begin
                    if (scanByte == 8'hE0) begin
                        stateNext = S_EXT;
                    end else if (scanByte == 8'hF0) begin
                        stateNext = S_BRK;
                    end else if (letterHit) begin
`ifdef TYPEMATIC_FILTER_EN
                        if (!heldMask[letterIdx]) cmdNext = {1'b1, letterIdx};
                        heldNext[letterIdx] = 1'b1;
`else
                        cmdNext = {1'b1, letterIdx};
`endif
                    end
                end
                S_EXT: begin
                    if (scanByte == 8'hF0) begin
                        stateNext = S_EXT_BRK;
                    end else begin
                        stateNext = S_IDLE;
                        if (arrowHit) begin
`ifdef TYPEMATIC_FILTER_EN
                            if (!heldMask[arrowIdx]) cmdNext = {1'b1, arrowIdx};
                            heldNext[arrowIdx] = 1'b1;
`else
                            cmdNext = {1'b1, arrowIdx};
`endif
                        end
                    end
                end
                S_BRK: begin
                    stateNext = S_IDLE;
`ifdef TYPEMATIC_FILTER_EN
                    if (letterHit) heldNext[letterIdx] = 1'b0;
`endif
                end
                S_EXT_BRK: begin
                    stateNext = S_IDLE;
`ifdef TYPEMATIC_FILTER_EN
                    if (arrowHit) heldNext[arrowIdx] = 1'b0;
`endif
                end
                default: stateNext = S_IDLE;
            endcase
        end
    end

    // Decoder state and the registered 1-cycle command pulse
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            keyCode  <= 3'b000;
            keyValid <= 1'b0;
        end else begin
            state    <= stateNext;
            keyCode  <= cmdNext;
            keyValid <= cmdNext[2];
        end
    end

`ifdef TYPEMATIC_FILTER_EN
    // Held-key mask: set on make, cleared on break
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            heldMask <= 4'b0000;
        end else begin
            heldMask <= heldNext;
        end
    end
`endif

    assign bus.keyboard_signal = keyCode;
    assign bus.key_valid       = keyValid;
    assign bus.scan_byte       = scanByte;
    assign bus.byte_valid      = byteValid;
    assign bus.frame_err       = frameErr;
endmodule

// File: tb/tb_ps2_key_decoder.sv
// Self-checking bench for ps2_key_decoder.
// Compares logged byte/command/error activity against a key-press model.
`timescale 1ns/1ps
module tb_ps2_key_decoder;
    localparam int TO   = 300;
    localparam int HALF = 6;
`ifdef TYPEMATIC_FILTER_EN
    localparam int TYP_EXP = 2;
`else
    localparam int TYP_EXP = 5;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ps2_key_decoder_if bus();

    ps2_key_decoder #(.TIMEOUT_CYCLES(TO)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int fails = 0;
    logic [7:0] byteLog[$];
    logic [7:0] expBytes[$];
    logic [2:0] cmdLog[$];
    logic [2:0] expCmds[$];
    int errCnt = 0;
    int expErr = 0;
    int misalign = 0;
    int badIdle = 0;
    logic prevBv = 1'b0;
    bit mExt, mBrk;
    bit mHeld[4];
    bit ok;

    // Activity logger, sampled away from the active edge
    always @(negedge clk) begin
        if (bus.byte_valid === 1'b1) byteLog.push_back(bus.scan_byte);
        if (bus.frame_err === 1'b1) errCnt++;
        if (bus.key_valid === 1'b1) begin
            cmdLog.push_back(bus.keyboard_signal);
            if (prevBv !== 1'b1) misalign++;
        end else if (bus.keyboard_signal !== 3'b000) begin
            badIdle++;
        end
        prevBv = bus.byte_valid;
    end

    function automatic int letterKey(logic [7:0] b);
        case (b)
            8'h1B: return 0;
            8'h1C: return 1;
            8'h23: return 2;
            8'h1D: return 3;
            default: return -1;
        endcase
    endfunction

    function automatic int arrowKey(logic [7:0] b);
        case (b)
            8'h72: return 0;
            8'h6B: return 1;
            8'h74: return 2;
            8'h75: return 3;
            default: return -1;
        endcase
    endfunction

    function automatic string fmtBytes(logic [7:0] q[$]);
        string s = "";
        foreach (q[i]) s = {s, $sformatf("%02h ", q[i])};
        return s;
    endfunction

    function automatic string fmtCmds(logic [2:0] q[$]);
        string s = "";
        foreach (q[i]) s = {s, $sformatf("%03b ", q[i])};
        return s;
    endfunction

    task automatic resetModel();
        mExt = 0;
        mBrk = 0;
        foreach (mHeld[i]) mHeld[i] = 0;
    endtask

    // Key-press rules: E0 prefix, F0 release, last byte names the key
    task automatic modelByte(input logic [7:0] b);
        int k;
        expBytes.push_back(b);
        if (b == 8'hE0 && !mExt && !mBrk) begin
            mExt = 1;
        end else if (b == 8'hF0 && !mBrk) begin
            mBrk = 1;
        end else begin
            k = mExt ? arrowKey(b) : letterKey(b);
            if (k >= 0) begin
                if (mBrk) begin
                    mHeld[k] = 0;
                end else begin
`ifdef TYPEMATIC_FILTER_EN
                    if (!mHeld[k]) expCmds.push_back(3'(4 + k));
`else
                    expCmds.push_back(3'(4 + k));
`endif
                    mHeld[k] = 1;
                end
            end
            mExt = 0;
            mBrk = 0;
        end
    endtask

    task automatic startCheck();
        byteLog.delete();
        expBytes.delete();
        cmdLog.delete();
        expCmds.delete();
        errCnt = 0;
        expErr = 0;
        misalign = 0;
        badIdle = 0;
    endtask

    task automatic resetDut();
        @(posedge clk);
        #2 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        resetModel();
    endtask

    task automatic sendBits(input logic [10:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            bus.ps2_data = bits[i];
            repeat (HALF) @(posedge clk);
            #2 bus.ps2_clk = 1'b0;
            repeat (HALF) @(posedge clk);
            #2 bus.ps2_clk = 1'b1;
        end
        bus.ps2_data = 1'b1;
    endtask

    // mode 0 good, 1 wrong parity, 2 stop bit low
    task automatic sendFrame(input logic [7:0] b, input int mode);
        logic par;
        logic stp;
        par = ~(^b) ^ (mode == 1);
        stp = (mode != 2);
        sendBits({stp, par, b, 1'b0}, 11);
        repeat (4) @(posedge clk);
        if (mode == 0) modelByte(b);
        else expErr++;
    endtask

    task automatic test_reset();
        bus.ps2_clk = 1'b1;
        bus.ps2_data = 1'b1;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if (bus.keyboard_signal !== 3'b000) begin
            fails++;
            $display("FAIL reset_cmd: got %b want 000", bus.keyboard_signal);
        end
        checks++;
        if (bus.key_valid !== 1'b0) begin
            fails++;
            $display("FAIL reset_key_valid: got %b want 0", bus.key_valid);
        end
        checks++;
        if (bus.byte_valid !== 1'b0) begin
            fails++;
            $display("FAIL reset_byte_valid: got %b want 0", bus.byte_valid);
        end
        checks++;
        if (bus.frame_err !== 1'b0) begin
            fails++;
            $display("FAIL reset_frame_err: got %b want 0", bus.frame_err);
        end
        checks++;
        if (bus.scan_byte !== 8'h00) begin
            fails++;
            $display("FAIL reset_scan_byte: got %h want 00", bus.scan_byte);
        end
        @(posedge clk);
        #2 rst_n = 1'b1;
        resetModel();
    endtask

    task automatic test_single();
        startCheck();
        sendFrame(8'h1C, 0);
        checks++;
        if (bus.scan_byte !== 8'h1C) begin
            fails++;
            $display("FAIL single_scan: got %h want 1c", bus.scan_byte);
        end
        ok = (cmdLog.size() == 1) && (cmdLog[0] === 3'b101);
        checks++;
        if (!ok) begin
            fails++;
            $display("FAIL single_cmd: got %s want 101", fmtCmds(cmdLog));
        end
        checks++;
        if (misalign !== 0 || badIdle !== 0) begin
            fails++;
            $display("FAIL single_shape: got misalign=%0d idle=%0d want 0/0", misalign, badIdle);
        end
    endtask

    task automatic test_extended();
        logic [7:0] seq[$] = '{8'hE0, 8'h75, 8'hE0, 8'hF0, 8'h75, 8'hF0, 8'h1D, 8'h1D};
        startCheck();
        foreach (seq[i]) sendFrame(seq[i], 0);
        ok = (cmdLog.size() == 2) && (cmdLog[0] === 3'b111) && (cmdLog[1] === 3'b111);
        checks++;
        if (!ok) begin
            fails++;
            $display("FAIL ext_cmds: got %s want 111 111", fmtCmds(cmdLog));
        end
        ok = (byteLog.size() == expBytes.size());
        foreach (expBytes[i]) if (ok && byteLog[i] !== expBytes[i]) ok = 0;
        checks++;
        if (!ok) begin
            fails++;
            $display("FAIL ext_bytes: got %s want %s", fmtBytes(byteLog), fmtBytes(expBytes));
        end
        checks++;
        if (misalign !== 0 || badIdle !== 0 || errCnt !== 0) begin
            fails++;
            $display("FAIL ext_shape: got misalign=%0d idle=%0d err=%0d want 0/0/0", misalign, badIdle, errCnt);
        end
    endtask

    task automatic test_parity();
        startCheck();
        sendFrame(8'h1B, 1);
        checks++;
        if (errCnt !== 1 || byteLog.size() !== 0 || cmdLog.size() !== 0) begin
            fails++;
            $display("FAIL parity_bad: got err=%0d bytes=%0d cmds=%0d want 1/0/0", errCnt, byteLog.size(), cmdLog.size());
        end
        checks++;
        if (bus.scan_byte !== 8'h1D) begin
            fails++;
            $display("FAIL parity_hold: got %h want 1d", bus.scan_byte);
        end
        sendFrame(8'h1B, 0);
        ok = (cmdLog.size() == 1) && (cmdLog[0] === 3'b100);
        checks++;
        if (!ok) begin
            fails++;
            $display("FAIL parity_good_cmd: got %s want 100", fmtCmds(cmdLog));
        end
        sendFrame(8'h23, 2);
        checks++;
        if (errCnt !== 2 || byteLog.size() !== 1) begin
            fails++;
            $display("FAIL stop_bad: got err=%0d bytes=%0d want 2/1", errCnt, byteLog.size());
        end
    endtask

    task automatic test_timeout();
        startCheck();
        sendBits({3'b111, 8'h23}, 4);
        repeat (TO - 20) @(posedge clk);
        checks++;
        if (errCnt !== 0) begin
            fails++;
            $display("FAIL timeout_early: got err=%0d want 0", errCnt);
        end
        repeat (40) @(posedge clk);
        checks++;
        if (errCnt !== 1) begin
            fails++;
            $display("FAIL timeout_fire: got err=%0d want 1", errCnt);
        end
        sendFrame(8'h23, 0);
        ok = (cmdLog.size() == 1) && (cmdLog[0] === 3'b110);
        checks++;
        if (!ok || errCnt !== 1) begin
            fails++;
            $display("FAIL timeout_recover: got %s err=%0d want 110 err=1", fmtCmds(cmdLog), errCnt);
        end
    endtask

    task automatic test_typematic();
        logic [7:0] seq[$] = '{8'h1C, 8'h1C, 8'h1C, 8'hF0, 8'h1C, 8'h1C, 8'h1C};
        resetDut();
        startCheck();
        foreach (seq[i]) sendFrame(seq[i], 0);
        ok = (cmdLog.size() == TYP_EXP);
        foreach (cmdLog[i]) if (cmdLog[i] !== 3'b101) ok = 0;
        checks++;
        if (!ok) begin
            fails++;
            $display("FAIL typematic_count: got %s want %0d x 101", fmtCmds(cmdLog), TYP_EXP);
        end
        ok = (cmdLog.size() == expCmds.size());
        foreach (expCmds[i]) if (ok && cmdLog[i] !== expCmds[i]) ok = 0;
        checks++;
        if (!ok) begin
            fails++;
            $display("FAIL typematic_model: got %s want %s", fmtCmds(cmdLog), fmtCmds(expCmds));
        end
    endtask

    task automatic test_random();
        logic [7:0] pool[$] = '{8'h1B, 8'h1C, 8'h23, 8'h1D, 8'h72, 8'h6B, 8'h74, 8'h75, 8'hE0, 8'hF0, 8'hF0, 8'hE0};
        logic [7:0] b;
        int r;
        startCheck();
        for (int n = 0; n < 40; n++) begin
            r = $urandom_range(0, 99);
            if (r < 8) begin
                sendBits(11'h7FF, 1);
            end else begin
                if ($urandom_range(0, 5) == 0) b = 8'($urandom);
                else b = pool[$urandom_range(0, pool.size() - 1)];
                sendFrame(b, (r < 16) ? 1 : ((r < 20) ? 2 : 0));
            end
            repeat ($urandom_range(0, 20)) @(posedge clk);
        end
        ok = (cmdLog.size() == expCmds.size());
        foreach (expCmds[i]) if (ok && cmdLog[i] !== expCmds[i]) ok = 0;
        checks++;
        if (!ok) begin
            fails++;
            $display("FAIL rand_cmds: got %s want %s", fmtCmds(cmdLog), fmtCmds(expCmds));
        end
        ok = (byteLog.size() == expBytes.size());
        foreach (expBytes[i]) if (ok && byteLog[i] !== expBytes[i]) ok = 0;
        checks++;
        if (!ok) begin
            fails++;
            $display("FAIL rand_bytes: got %s want %s", fmtBytes(byteLog), fmtBytes(expBytes));
        end
        checks++;
        if (errCnt !== expErr || misalign !== 0 || badIdle !== 0) begin
            fails++;
            $display("FAIL rand_shape: got err=%0d misalign=%0d idle=%0d want %0d/0/0", errCnt, misalign, badIdle, expErr);
        end
    endtask

    task automatic test_reset_midframe();
        startCheck();
        sendFrame(8'hE0, 0);
        sendBits({3'b111, 8'h1D}, 5);
        resetDut();
        startCheck();
        repeat (5) @(posedge clk);
        sendFrame(8'h1D, 0);
        ok = (cmdLog.size() == 1) && (cmdLog[0] === 3'b111);
        checks++;
        if (!ok || errCnt !== 0) begin
            fails++;
            $display("FAIL midreset: got %s err=%0d want 111 err=0", fmtCmds(cmdLog), errCnt);
        end
        checks++;
        if (byteLog.size() !== 1 || bus.scan_byte !== 8'h1D) begin
            fails++;
            $display("FAIL midreset_byte: got n=%0d %h want 1 1d", byteLog.size(), bus.scan_byte);
        end
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        resetModel();
        test_reset();
        test_single();
        test_extended();
        test_parity();
        test_timeout();
        test_typematic();
        test_random();
        test_reset_midframe();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
